// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, FIFO defaults and index helper for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_DEPTH  = 64;
    localparam int FIFO_DATA_W = 8;

    // Next round-robin start position after idx, wrapping the last requester to 0.
    function automatic int rr_next(input int idx, input int num_req);
        int nxt;
        if (idx >= num_req - 1) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker; the first asserted req at or after rr wins.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);

    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W:0]     off_s;
    logic [IDX_W:0]     sum_s;

    // Rotate the request vector so that position 0 is the current rr slot.
    assign rot_s = NUM_REQ'({req, req} >> rr);

    // Scan downward so the lowest rotated hit is the one left in off_s.
    always_comb begin
        found = 1'b0;
        off_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                found = 1'b1;
                off_s = (IDX_W + 1)'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, rr} + off_s;
        if (sum_s >= (IDX_W + 1)'(NUM_REQ)) begin
            sum_s = sum_s - (IDX_W + 1)'(NUM_REQ);
        end else begin
            sum_s = sum_s;
        end
        win_idx = sum_s[IDX_W-1:0];
        if (found) begin
            win_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << win_idx;
        end else begin
            win_onehot = '0;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to build the IDLE/BURST lock of up to MAX_BURST beats per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int CNT_W     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic [CNT_W-1:0]           fifo_counter,
    input  logic                       buf_full,
    output logic                       wr_en,
    output logic [DATA_W-1:0]          buf_in,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);

    localparam int             IDX_W   = $clog2(NUM_REQ);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_range
        $error("fifo_wr_arbiter: NUM_REQ or MAX_BURST out of range");
    end

    logic [NUM_REQ-1:0] win_onehot_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               found_s;
    logic [CNT_W:0]     occ_sum_s;
    logic               space_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               gnt_any_s;
    logic [DATA_W-1:0]  gnt_data_s;
    logic [IDX_W-1:0]   rr_r;
    logic [IDX_W-1:0]   owner_r;
    logic               wr_en_r;
    logic [DATA_W-1:0]  buf_in_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .rr         (rr_r),
        .win_onehot (win_onehot_s),
        .win_idx    (win_idx_s),
        .found      (found_s)
    );

    // The in-flight write is counted so a beat granted now still has a slot when it lands.
    assign occ_sum_s  = {1'b0, fifo_counter} + {{CNT_W{1'b0}}, wr_en_r};
    assign space_s    = !buf_full && (occ_sum_s < DEPTH_C);
    assign gnt_data_s = req_data[int'(gnt_idx_s) * DATA_W +: DATA_W];

    assign gnt    = rst ? '0 : gnt_s;
    assign wr_en  = wr_en_r;
    assign buf_in = buf_in_r;
    assign owner  = owner_r;

    // Write port register: one accepted beat becomes one FIFO write on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r  <= 1'b0;
            buf_in_r <= '0;
        end else if (gnt_any_s) begin
            wr_en_r  <= 1'b1;
            buf_in_r <= gnt_data_s;
        end else begin
            wr_en_r  <= 1'b0;
            buf_in_r <= buf_in_r;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state_r;
    arb_state_t        state_s;
    logic [BEAT_W-1:0] beats_r;
    logic [BEAT_W-1:0] beats_s;
    logic [IDX_W-1:0]  rr_s;
    logic [IDX_W-1:0]  owner_s;
    logic              busy_r;

    // Burst FSM: lock a winner until it drops req or reaches MAX_BURST, then release for one cycle.
    always_comb begin
        state_s   = state_r;
        beats_s   = beats_r;
        rr_s      = rr_r;
        owner_s   = owner_r;
        gnt_s     = '0;
        gnt_idx_s = owner_r;
        gnt_any_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s && space_s) begin
                    gnt_s     = win_onehot_s;
                    gnt_idx_s = win_idx_s;
                    gnt_any_s = 1'b1;
                    owner_s   = win_idx_s;
                    beats_s   = BEAT_W'(1);
                    state_s   = BURST;
                end else begin
                    state_s   = IDLE;
                end
            end
            BURST: begin
                if (!req[owner_r] || (beats_r == BEAT_W'(MAX_BURST))) begin
                    rr_s    = IDX_W'(rr_next(int'(owner_r), NUM_REQ));
                    state_s = IDLE;
                end else if (space_s) begin
                    gnt_s[owner_r] = 1'b1;
                    gnt_any_s      = 1'b1;
                    beats_s        = beats_r + BEAT_W'(1);
                end else begin
                    state_s = BURST;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Burst FSM state and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            beats_r <= '0;
            rr_r    <= '0;
            owner_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            beats_r <= beats_s;
            rr_r    <= rr_s;
            owner_r <= owner_s;
            busy_r  <= (state_s == BURST);
        end
    end

    assign busy = busy_r;
`else
    // Single-beat mode: every cycle with space grants the round-robin winner.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = win_idx_s;
        gnt_any_s = 1'b0;
        if (space_s && found_s) begin
            gnt_s     = win_onehot_s;
            gnt_any_s = 1'b1;
        end else begin
            gnt_s     = '0;
            gnt_any_s = 1'b0;
        end
    end

    // Pointer moves past each winner on the same edge, so different requesters alternate with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r    <= '0;
            owner_r <= '0;
        end else if (gnt_any_s) begin
            rr_r    <= IDX_W'(rr_next(int'(gnt_idx_s), NUM_REQ));
            owner_r <= gnt_idx_s;
        end else begin
            rr_r    <= rr_r;
            owner_r <= owner_r;
        end
    end

    assign busy = 1'b0;
`endif

endmodule
